// File: rtl/stream_pkg.sv
// Shared definitions for the stream source generator.
//   state_t             : FSM state encoding
//   LFSR16_TAPS         : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   LFSR16_DEFAULT_SEED : reset value used when no seed is supplied
//   lfsr16_next()       : one Fibonacci shift step
package stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [15:0] LFSR16_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR16_DEFAULT_SEED = 16'hACE1;

  // Shift toward the MSB and feed the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR16_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to throttle the stream valid.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high, loads the seed
//   en    : advance one step this cycle
//   seed  : reset value; an all-zero seed is replaced by 16'h0001
//   q     : current register value
module lfsr16
  import stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // An all-zero register is a lock-up state, so never load it.
  logic [15:0] seed_safe;
  assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed_safe;
    end else if (en) begin
      q <= lfsr16_next(q);
    end
  end

endmodule

// File: rtl/stream_src_gen.sv
// Valid/ready stream transmitter. A run request sends a programmed number
// of beats carrying an incrementing data sequence, optionally throttled by
// an LFSR.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   i_run        : start request, only honoured in IDLE
//   i_num_beats  : beat count, latched on accept
//   i_start_val  : data of beat 0, latched on accept
//   i_throttle   : 1 = gate valid with LFSR bit 0
//   m_valid/m_ready/m_data : master stream port
//   o_busy       : high while in RUN
//   o_done       : one-cycle pulse in DONE
//   o_beat_cnt   : handshakes completed in the current/last run
//
// state  | meaning
// S_IDLE | waiting for i_run
// S_RUN  | emitting beats until the last handshake
// S_DONE | single-cycle completion pulse, then back to IDLE
module stream_src_gen
  import stream_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR16_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic [LEN_W-1:0]  i_num_beats,
  input  logic [DATA_W-1:0] i_start_val,
  input  logic              i_throttle,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_beat_cnt
);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  num_q, num_nxt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              hs, last_hs;
  logic [15:0]       lfsr_q;
  logic              lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_RUN),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only bit 0 drives the throttle decision.
  assign lfsr_unused = ^lfsr_q[15:1];

  assign hs      = m_valid & m_ready;
  assign last_hs = hs && (o_beat_cnt == num_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      num_q      <= '0;
      o_beat_cnt <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      num_q      <= num_nxt;
      o_beat_cnt <= cnt_nxt;
      m_data     <= data_nxt;
      m_valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num_nxt   = num_q;
    cnt_nxt   = o_beat_cnt;
    data_nxt  = m_data;
    valid_nxt = m_valid;

    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (i_run) begin
          num_nxt   = i_num_beats;
          cnt_nxt   = '0;
          data_nxt  = i_start_val;
          state_nxt = (i_num_beats != '0) ? S_RUN : S_DONE;
        end
      end

      S_RUN: begin
        if (hs) begin
          cnt_nxt  = o_beat_cnt + LEN_W'(1);
          data_nxt = m_data + DATA_W'(1);
        end
        // A raised valid is only re-decided once it has been consumed,
        // so an offered beat is never withdrawn.
        if (last_hs) begin
          valid_nxt = 1'b0;
          state_nxt = S_DONE;
        end else if (!m_valid || hs) begin
          valid_nxt = i_throttle ? lfsr_q[0] : 1'b1;
        end
      end

      S_DONE: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_busy = (state == S_RUN);
  assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_stream_src_gen.sv
// Self-checking bench for stream_src_gen: table-driven runs scored against
// an expected-beat queue, plus hand-written backpressure and reset cases.
module tb_stream_src_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run;
  logic [15:0] i_num_beats;
  logic [31:0] i_start_val;
  logic        i_throttle;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_beat_cnt;

  int checks = 0;
  int errors = 0;

  stream_src_gen dut (
    .clk         (clk),
    .reset       (reset),
    .i_run       (i_run),
    .i_num_beats (i_num_beats),
    .i_start_val (i_start_val),
    .i_throttle  (i_throttle),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_beat_cnt  (o_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          num;
    logic [31:0] start;
    bit          thr;
    bit          rnd_ready;
    int          exp_beats;
    logic [31:0] exp_last;
    int          exp_cycles;  // accept edge to o_done, -1 = not checked
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is 1 time unit after an edge with the DUT in IDLE.
  task automatic do_run(input vec_t v);
    logic [31:0] exp_q[$];
    logic [31:0] last_d;
    logic [31:0] pd;
    bit          pv, pr;
    int          hs_n, done_n, cyc, vbad;
    hs_n = 0; done_n = 0; cyc = 0; vbad = 0; pv = 0; pr = 0; pd = '0; last_d = '0;
    for (int i = 0; i < v.num; i++) exp_q.push_back(v.start + 32'(i));

    i_num_beats = 16'(v.num);
    i_start_val = v.start;
    i_throttle  = v.thr;
    i_run       = 1'b1;
    m_ready     = v.rnd_ready ? 1'($urandom % 2) : 1'b1;
    step();
    i_run = 1'b0;
    check_eq("busy_after_accept", 32'(o_busy), 32'(v.num != 0));
    check_eq("cnt_after_accept", 32'(o_beat_cnt), 32'd0);

    while (cyc < 3000) begin
      if (pv && !pr) begin
        if (!m_valid || m_data !== pd) vbad++;
      end
      if (o_done) begin
        done_n++;
        break;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got 0x%08h expected no beat", m_data);
        end else begin
          check_eq("beat_data", m_data, exp_q.pop_front());
        end
        last_d = m_data;
        hs_n++;
      end
      pv = m_valid; pr = m_ready; pd = m_data;
      step();
      cyc++;
      if (v.rnd_ready) m_ready = 1'($urandom % 2);
    end

    check_eq("timeout", 32'(cyc >= 3000), 32'd0);
    check_eq("no_retract", 32'(vbad), 32'd0);
    check_eq("done_seen", 32'(done_n), 32'd1);
    check_eq("valid_in_done", 32'(m_valid), 32'd0);
    check_eq("hs_count", 32'(hs_n), 32'(v.exp_beats));
    check_eq("missing_beats", 32'(exp_q.size()), 32'd0);
    check_eq("beat_cnt_final", 32'(o_beat_cnt), 32'(v.exp_beats));
    if (v.exp_beats > 0) check_eq("last_data", last_d, v.exp_last);
    if (v.exp_cycles >= 0) check_eq("run_cycles", 32'(cyc), 32'(v.exp_cycles));
    m_ready = 1'b1;
    step();
    check_eq("done_one_cycle", 32'(o_done), 32'd0);
    check_eq("idle_after_done", 32'(o_busy), 32'd0);
    check_eq("beat_cnt_hold", 32'(o_beat_cnt), 32'(v.exp_beats));
  endtask

  initial begin : main
    int n;
    reset = 1'b1; i_run = 1'b0; i_num_beats = '0; i_start_val = '0;
    i_throttle = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", m_data, 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_cnt", 32'(o_beat_cnt), 32'd0);
    reset = 1'b0;
    step();

    //                 num  start          thr rnd beats last          cycles
    vecs.push_back('{  4,  32'h0,          0,  0,  4,   32'h3,         5 });
    vecs.push_back('{  3,  32'hFFFF_FFFE,  0,  0,  3,   32'h0,         4 });
    vecs.push_back('{100,  32'h0,          1,  1,  100, 32'd99,        -1});
    vecs.push_back('{  0,  32'h1234,       0,  0,  0,   32'h0,         0 });
    vecs.push_back('{  7,  32'h5,          1,  0,  7,   32'hB,         -1});
    vecs.push_back('{  5,  32'hA,          0,  1,  5,   32'hE,         -1});
    vecs.push_back('{  1,  32'hFFFF_FFFF,  0,  0,  1,   32'hFFFF_FFFF, 2 });
    foreach (vecs[i]) do_run(vecs[i]);

    // Backpressure: valid and data frozen while ready is low; i_run mid-run ignored.
    i_num_beats = 16'd2; i_start_val = 32'hCAFE_0000; i_throttle = 1'b0;
    m_ready = 1'b0; i_run = 1'b1;
    step();
    i_run = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin step(); n++; end
    check_eq("bp_valid_rise", 32'(m_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      i_run = (i == 3); i_num_beats = 16'd50; i_start_val = 32'd999;
      step();
      check_eq("bp_valid_hold", 32'(m_valid), 32'd1);
      check_eq("bp_data_hold", m_data, 32'hCAFE_0000);
    end
    i_run = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (!o_done && n < 20) begin step(); n++; end
    check_eq("bp_done", 32'(o_done), 32'd1);
    check_eq("bp_cnt", 32'(o_beat_cnt), 32'd2);
    step();

    // Reset mid-run after 5 of 20 beats.
    i_num_beats = 16'd20; i_start_val = 32'h100; i_throttle = 1'b0; m_ready = 1'b1;
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (m_valid && m_ready) n++;
      step();
    end
    check_eq("mid_cnt", 32'(o_beat_cnt), 32'd5);
    check_eq("mid_data", m_data, 32'h105);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mrst_valid", 32'(m_valid), 32'd0);
    check_eq("mrst_busy", 32'(o_busy), 32'd0);
    check_eq("mrst_cnt", 32'(o_beat_cnt), 32'd0);
    check_eq("mrst_data", m_data, 32'd0);
    do_run('{2, 32'h77, 0, 0, 2, 32'h78, 3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
